// File: rtl/sprite_draw_if.sv
// Command, sprite-memory and framebuffer signals of the sprite draw engine.
// The engine connects through the slave modport; the host/memory side uses master.
interface sprite_draw_if;
    logic        start_in;
    logic        op_in;
    logic [7:0]  x_in;
    logic [7:0]  y_in;
    logic [3:0]  n_in;
    logic [11:0] i_in;
    logic [11:0] spr_addr_out;
    logic [7:0]  spr_data_in;
    logic [15:0] fb_addr_out;
    logic [7:0]  fb_data_in;
    logic [7:0]  fb_data_out;
    logic        fb_we_out;
    logic        busy_out;
    logic        done_out;
    logic        collision_out;

    modport master (
        output start_in, op_in, x_in, y_in, n_in, i_in, spr_data_in, fb_data_in,
        input  spr_addr_out, fb_addr_out, fb_data_out, fb_we_out, busy_out, done_out, collision_out
    );

    modport slave (
        input  start_in, op_in, x_in, y_in, n_in, i_in, spr_data_in, fb_data_in,
        output spr_addr_out, fb_addr_out, fb_data_out, fb_we_out, busy_out, done_out, collision_out
    );
endinterface

// File: rtl/sprite_draw_engine.sv
// CHIP-8 style sprite XOR-draw and screen clear into a 64x32 byte-packed framebuffer.
// Both memories have a two-cycle read latency; every output is registered.
module sprite_draw_engine (
    input  logic          clk_in,
    input  logic          rst_in,
    sprite_draw_if.slave  bus
);
    localparam int unsigned ADDR_W = 12;
    localparam int unsigned FBA_W  = 16;
    localparam int unsigned BYTE_W = 8;
    localparam int unsigned ROW_W  = 5;
    localparam int unsigned COL_W  = 3;

    typedef enum logic [3:0] {
        IDLE, SPR_REQ, SPR_WAIT, FB0_REQ, FB0_WAIT, FB0_WR,
        FB1_REQ, FB1_WAIT, FB1_WR, CLEAR, DONE
    } state_t;

    state_t              state_q, state_d;
    logic                wait_q, wait_d;
    logic [5:0]          x_q, x_d;
    logic [ROW_W-1:0]    y_q, y_d;
    logic [3:0]          n_q, n_d;
    logic [3:0]          r_q, r_d;
    logic [ADDR_W-1:0]   i_q, i_d;
    logic [BYTE_W-1:0]   spr_q, spr_d;
    logic                coll_q, coll_d;
    logic [ADDR_W-1:0]   spr_addr_q, spr_addr_d;
    logic [FBA_W-1:0]    fb_addr_q, fb_addr_d;
    logic [BYTE_W-1:0]   fb_data_q, fb_data_d;
    logic                fb_we_q, fb_we_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                collision_q, collision_d;

    logic [15:0]         window;
    logic [ROW_W-1:0]    row;
    logic [ROW_W-1:0]    r_inc;
    logic [5:0]          y_end;
    logic                unaligned;
    logic                row_end;

    // Origin coordinates are taken modulo the screen size, so the high bits are dropped.
    logic unused_bits;
    assign unused_bits = ^{bus.x_in[7:6], bus.y_in[7:5]};

    // Next-state and next-output logic.
    always_comb begin
        state_d     = state_q;
        wait_d      = 1'b0;
        x_d         = x_q;
        y_d         = y_q;
        n_d         = n_q;
        r_d         = r_q;
        i_d         = i_q;
        spr_d       = spr_q;
        coll_d      = coll_q;
        spr_addr_d  = spr_addr_q;
        fb_addr_d   = fb_addr_q;
        fb_data_d   = fb_data_q;
        fb_we_d     = 1'b0;
        collision_d = collision_q;
        row_end     = 1'b0;

        window    = {spr_q, 8'h00} >> x_q[2:0];
        row       = y_q + ROW_W'(r_q);
        r_inc     = ROW_W'(r_q) + 5'd1;
        y_end     = 6'(y_q) + 6'(r_inc);
        unaligned = (x_q[2:0] != 3'd0) && (x_q[5:3] != 3'd7);

        case (state_q)
            IDLE: begin
                if (bus.start_in) begin
                    x_d         = bus.x_in[5:0];
                    y_d         = bus.y_in[4:0];
                    n_d         = bus.n_in;
                    i_d         = bus.i_in;
                    r_d         = 4'd0;
                    coll_d      = 1'b0;
                    collision_d = 1'b0;
                    if (bus.op_in) begin
                        state_d   = CLEAR;
                        fb_addr_d = 16'h0000;
                        fb_data_d = 8'h00;
                        fb_we_d   = 1'b1;
                    end else if (bus.n_in == 4'd0) begin
                        state_d = DONE;
                    end else begin
                        state_d    = SPR_REQ;
                        spr_addr_d = bus.i_in;
                    end
                end
            end
            SPR_REQ: state_d = SPR_WAIT;
            SPR_WAIT: begin
                if (wait_q) begin
                    spr_d     = bus.spr_data_in;
                    state_d   = FB0_REQ;
                    fb_addr_d = {8'h00, row, x_q[5:3]};
                end else begin
                    wait_d = 1'b1;
                end
            end
            FB0_REQ: state_d = FB0_WAIT;
            FB0_WAIT: begin
                if (wait_q) begin
                    state_d   = FB0_WR;
                    fb_data_d = bus.fb_data_in ^ window[15:8];
                    fb_we_d   = 1'b1;
                    coll_d    = coll_q | (|(bus.fb_data_in & window[15:8]));
                end else begin
                    wait_d = 1'b1;
                end
            end
            FB0_WR: begin
                if (unaligned) begin
                    state_d   = FB1_REQ;
                    fb_addr_d = {8'h00, row, x_q[5:3] + COL_W'(1)};
                end else begin
                    row_end = 1'b1;
                end
            end
            FB1_REQ: state_d = FB1_WAIT;
            FB1_WAIT: begin
                if (wait_q) begin
                    state_d   = FB1_WR;
                    fb_data_d = bus.fb_data_in ^ window[7:0];
                    fb_we_d   = 1'b1;
                    coll_d    = coll_q | (|(bus.fb_data_in & window[7:0]));
                end else begin
                    wait_d = 1'b1;
                end
            end
            FB1_WR: row_end = 1'b1;
            CLEAR: begin
                if (fb_addr_q[7:0] == 8'hFF) begin
                    state_d = DONE;
                end else begin
                    fb_addr_d = fb_addr_q + 16'd1;
                    fb_we_d   = 1'b1;
                end
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        // Bottom edge clips: a row that would land on line 32 ends the draw.
        if (row_end) begin
            r_d = r_q + 4'd1;
            if ((r_inc == ROW_W'(n_q)) || (y_end == 6'd32)) begin
                state_d = DONE;
            end else begin
                state_d    = SPR_REQ;
                spr_addr_d = i_q + ADDR_W'(r_inc);
            end
        end

        busy_d = (state_d != IDLE) && (state_d != DONE);
        done_d = (state_d == DONE);
        if (state_d == DONE) begin
            collision_d = coll_d;
        end
    end

    // State and output registers.
    always_ff @(posedge clk_in) begin
        if (!rst_in) begin
            state_q     <= IDLE;
            wait_q      <= 1'b0;
            x_q         <= '0;
            y_q         <= '0;
            n_q         <= '0;
            r_q         <= '0;
            i_q         <= '0;
            spr_q       <= '0;
            coll_q      <= 1'b0;
            spr_addr_q  <= '0;
            fb_addr_q   <= '0;
            fb_data_q   <= '0;
            fb_we_q     <= 1'b0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            collision_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            x_q         <= x_d;
            y_q         <= y_d;
            n_q         <= n_d;
            r_q         <= r_d;
            i_q         <= i_d;
            spr_q       <= spr_d;
            coll_q      <= coll_d;
            spr_addr_q  <= spr_addr_d;
            fb_addr_q   <= fb_addr_d;
            fb_data_q   <= fb_data_d;
            fb_we_q     <= fb_we_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            collision_q <= collision_d;
        end
    end

    assign bus.spr_addr_out  = spr_addr_q;
    assign bus.fb_addr_out   = fb_addr_q;
    assign bus.fb_data_out   = fb_data_q;
    assign bus.fb_we_out     = fb_we_q;
    assign bus.busy_out      = busy_q;
    assign bus.done_out      = done_q;
    assign bus.collision_out = collision_q;
endmodule

// File: tb/tb_sprite_draw_engine.sv
// Directed bench for sprite_draw_engine: two-cycle-latency memory models,
// a table of draw commands with hand-computed results, plus clear and reset-abort sequences.
module tb_sprite_draw_engine;
    logic clk_in = 1'b0;
    logic rst_in;
    always #5 clk_in = ~clk_in;

    sprite_draw_if bus ();

    sprite_draw_engine dut (
        .clk_in (clk_in),
        .rst_in (rst_in),
        .bus    (bus)
    );

    logic [7:0]  spr_mem [4096];
    logic [7:0]  fb_mem  [256];
    logic [7:0]  spr_d1, fb_d1;
    logic        fb_zero = 1'b0;
    logic [15:0] log_addr [1024];
    logic [7:0]  log_data [1024];
    int          wcnt = 0;

    int tests = 0;
    int fails = 0;

    // Memory models with two-cycle read latency; the framebuffer also logs every write.
    always @(posedge clk_in) begin
        spr_d1          <= spr_mem[bus.spr_addr_out];
        bus.spr_data_in <= spr_d1;
        fb_d1           <= fb_mem[bus.fb_addr_out[7:0]];
        bus.fb_data_in  <= fb_d1;
        if (fb_zero) begin
            for (int k = 0; k < 256; k++) fb_mem[k] <= 8'h00;
        end else if (bus.fb_we_out === 1'b1) begin
            fb_mem[bus.fb_addr_out[7:0]] <= bus.fb_data_out;
            log_addr[wcnt % 1024]        <= bus.fb_addr_out;
            log_data[wcnt % 1024]        <= bus.fb_data_out;
            wcnt                         <= wcnt + 1;
        end
    end

    typedef struct {
        bit          clr;
        logic [7:0]  x;
        logic [7:0]  y;
        logic [3:0]  n;
        logic [11:0] i;
        logic [7:0]  s0;
        logic [7:0]  s1;
        int          nw;
        logic [15:0] a0;
        logic [7:0]  d0;
        logic [15:0] a1;
        logic [7:0]  d1;
        bit          coll;
        int          cyc;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h", nm, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic run_vec(input vec_t v, input string nm);
        int base;
        int cyc;
        bit seen;
        logic [11:0] i1;
        if (v.clr) begin
            fb_zero = 1'b1;
            tick();
            fb_zero = 1'b0;
        end
        i1 = v.i + 12'd1;
        spr_mem[v.i] = v.s0;
        spr_mem[i1]  = v.s1;
        base = wcnt;
        bus.start_in = 1'b1;
        bus.op_in    = 1'b0;
        bus.x_in     = v.x;
        bus.y_in     = v.y;
        bus.n_in     = v.n;
        bus.i_in     = v.i;
        cyc  = 0;
        seen = 1'b0;
        while (!seen && cyc < 400) begin
            tick();
            cyc++;
            if (cyc == 1) begin
                bus.start_in = 1'b0;
                if (v.n != 4'd0) begin
                    check({nm, "_busy"}, 32'(bus.busy_out), 32'd1);
                    check({nm, "_spr_addr"}, 32'(bus.spr_addr_out), 32'(v.i));
                end
            end
            if (bus.done_out === 1'b1) seen = 1'b1;
        end
        check({nm, "_cycles"}, 32'(cyc), 32'(v.cyc));
        check({nm, "_busy_at_done"}, 32'(bus.busy_out), 32'd0);
        check({nm, "_collision"}, 32'(bus.collision_out), 32'(v.coll));
        check({nm, "_nwrites"}, 32'(wcnt - base), 32'(v.nw));
        if (v.nw >= 1) begin
            check({nm, "_addr0"}, 32'(log_addr[base % 1024]), 32'(v.a0));
            check({nm, "_data0"}, 32'(log_data[base % 1024]), 32'(v.d0));
        end
        if (v.nw >= 2) begin
            check({nm, "_addr1"}, 32'(log_addr[(base + 1) % 1024]), 32'(v.a1));
            check({nm, "_data1"}, 32'(log_data[(base + 1) % 1024]), 32'(v.d1));
        end
        tick();
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int base;
        int cyc;
        int good;
        int done_cyc;
        bit seen;

        for (int k = 0; k < 4096; k++) spr_mem[k] = 8'h00;
        for (int k = 0; k < 256; k++)  fb_mem[k]  = 8'h00;

        //              clr   x      y      n  i        s0     s1     nw a0       d0     a1       d1     coll cyc
        vecs[0] = '{1'b1, 8'd8,  8'd0,  4'd1, 12'h200, 8'hF0, 8'h00, 1, 16'h0001, 8'hF0, 16'h0000, 8'h00, 1'b0, 8};
        vecs[1] = '{1'b1, 8'd3,  8'd2,  4'd1, 12'h210, 8'hFF, 8'h00, 2, 16'h0010, 8'h1F, 16'h0011, 8'hE0, 1'b0, 12};
        vecs[2] = '{1'b0, 8'd3,  8'd2,  4'd1, 12'h210, 8'hFF, 8'h00, 2, 16'h0010, 8'h00, 16'h0011, 8'h00, 1'b1, 12};
        vecs[3] = '{1'b0, 8'd0,  8'd0,  4'd0, 12'h000, 8'h00, 8'h00, 0, 16'h0000, 8'h00, 16'h0000, 8'h00, 1'b0, 1};
        vecs[4] = '{1'b1, 8'd61, 8'd30, 4'd4, 12'h220, 8'hFF, 8'hFF, 2, 16'h00F7, 8'h07, 16'h00FF, 8'h07, 1'b0, 15};
        vecs[5] = '{1'b1, 8'd16, 8'd5,  4'd2, 12'hFFF, 8'hA5, 8'h3C, 2, 16'h002A, 8'hA5, 16'h0032, 8'h3C, 1'b0, 15};
        vecs[6] = '{1'b0, 8'd20, 8'd5,  4'd1, 12'h300, 8'hF0, 8'h00, 2, 16'h002A, 8'hAA, 16'h002B, 8'h00, 1'b1, 12};
        vecs[7] = '{1'b1, 8'd72, 8'd33, 4'd1, 12'h400, 8'h81, 8'h00, 1, 16'h0009, 8'h81, 16'h0000, 8'h00, 1'b0, 8};
        vecs[8] = '{1'b0, 8'd8,  8'd0,  4'd1, 12'h200, 8'hF0, 8'h00, 1, 16'h0001, 8'hF0, 16'h0000, 8'h00, 1'b0, 8};

        rst_in       = 1'b0;
        bus.start_in = 1'b0;
        bus.op_in    = 1'b0;
        bus.x_in     = 8'd0;
        bus.y_in     = 8'd0;
        bus.n_in     = 4'd0;
        bus.i_in     = 12'd0;
        repeat (3) tick();
        check("rst_busy", 32'(bus.busy_out), 32'd0);
        check("rst_done", 32'(bus.done_out), 32'd0);
        check("rst_collision", 32'(bus.collision_out), 32'd0);
        check("rst_we", 32'(bus.fb_we_out), 32'd0);
        check("rst_fb_data", 32'(bus.fb_data_out), 32'd0);
        check("rst_fb_addr", 32'(bus.fb_addr_out), 32'd0);
        check("rst_spr_addr", 32'(bus.spr_addr_out), 32'd0);
        rst_in = 1'b1;
        repeat (2) tick();

        for (int t = 0; t < 8; t++) run_vec(vecs[t], $sformatf("vec%0d", t));

        // Clear: 256 back-to-back zero writes, done the cycle after; a mid-clear start is dropped.
        base = wcnt;
        good = 0;
        done_cyc = 0;
        seen = 1'b0;
        cyc = 0;
        bus.start_in = 1'b1;
        bus.op_in    = 1'b1;
        while (!seen && cyc < 600) begin
            tick();
            cyc++;
            if (cyc == 1) bus.start_in = 1'b0;
            if (cyc == 100) begin
                bus.start_in = 1'b1;
                bus.op_in    = 1'b0;
                bus.x_in     = 8'd0;
                bus.y_in     = 8'd0;
                bus.n_in     = 4'd1;
            end
            if (cyc == 101) bus.start_in = 1'b0;
            if (cyc <= 256 && bus.fb_we_out === 1'b1 &&
                bus.fb_addr_out === 16'(cyc - 1) && bus.fb_data_out === 8'h00) good++;
            if (bus.done_out === 1'b1) begin
                seen = 1'b1;
                done_cyc = cyc;
            end
        end
        check("clear_writes", 32'(good), 32'd256);
        check("clear_done_cycle", 32'(done_cyc), 32'd257);
        check("clear_collision", 32'(bus.collision_out), 32'd0);
        repeat (20) tick();
        check("clear_total_writes", 32'(wcnt - base), 32'd256);
        check("clear_idle_busy", 32'(bus.busy_out), 32'd0);

        // Reset asserted during FB0_WAIT aborts the draw without a write or done pulse.
        base = wcnt;
        seen = 1'b0;
        bus.start_in = 1'b1;
        bus.op_in    = 1'b0;
        bus.x_in     = 8'd8;
        bus.y_in     = 8'd0;
        bus.n_in     = 4'd1;
        bus.i_in     = 12'h200;
        for (int c = 1; c <= 5; c++) begin
            tick();
            if (c == 1) bus.start_in = 1'b0;
            if (bus.done_out === 1'b1) seen = 1'b1;
        end
        rst_in = 1'b0;
        tick();
        check("abort_busy", 32'(bus.busy_out), 32'd0);
        check("abort_we", 32'(bus.fb_we_out), 32'd0);
        tick();
        rst_in = 1'b1;
        for (int c = 0; c < 12; c++) begin
            tick();
            if (bus.done_out === 1'b1) seen = 1'b1;
        end
        check("abort_no_write", 32'(wcnt - base), 32'd0);
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_idle_busy", 32'(bus.busy_out), 32'd0);

        run_vec(vecs[8], "post_reset");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/sprite_draw_engine.md
SPRITE_DRAW_ENGINE -- requirements
Module: sprite_draw_engine

Interface
REQ-001: clk_in  input  1  single system clock; all logic on posedge.
REQ-002: rst_in  input  1  synchronous reset, active-low (0 = reset), sampled on posedge clk_in.
REQ-003: start_in  input  1  one-cycle command strobe; sampled only in IDLE.
REQ-004: op_in  input  1  0 = DRAW sprite, 1 = CLEAR screen; sampled with start_in.
REQ-005: x_in  input  8  sprite X; sampled with start_in.
REQ-006: y_in  input  8  sprite Y; sampled with start_in.
REQ-007: n_in  input  4  sprite height in rows (0-15); sampled with start_in.
REQ-008: i_in  input  12  sprite base address in CHIP-8 memory; sampled with start_in.
REQ-009: spr_addr_out  output  12  sprite memory read address.
REQ-010: spr_data_in  input  8  sprite byte; valid 2 cycles after address.
REQ-011: fb_addr_out  output  16  framebuffer address {8'b0, row[4:0], col_byte[2:0]}.
REQ-012: fb_data_in  input  8  framebuffer read data; valid 2 cycles after address; bit 7 = leftmost pixel.
REQ-013: fb_data_out  output  8  framebuffer write data.
REQ-014: fb_we_out  output  1  framebuffer write enable; one byte per asserted cycle.
REQ-015: busy_out  output  1  high from the cycle after an accepted start until done_out.
REQ-016: done_out  output  1  one-cycle pulse at command completion.
REQ-017: collision_out  output  1  CHIP-8 VF result; updated at done_out, held until next accepted start.

Function
REQ-018: Framebuffer is 64x32 pixels, 256 bytes, 8 bytes per row; X origin is x_in mod 64, Y origin is y_in mod 32.
REQ-019: States: IDLE, SPR_REQ, SPR_WAIT, FB0_REQ, FB0_WAIT, FB0_WR, FB1_REQ, FB1_WAIT, FB1_WR, CLEAR, DONE.
REQ-020: IDLE + start_in=1 + op_in=0 -> SPR_REQ with row r=0; IDLE + start_in=1 + op_in=1 -> CLEAR with address 0.
REQ-021: start_in outside IDLE is ignored; no queuing.
REQ-022: SPR_REQ drives spr_addr_out = (i_in + r) mod 4096, then SPR_WAIT for 2 cycles; spr_data_in is captured in the second SPR_WAIT cycle.
REQ-023: Shift window W[15:0] = {sprite_byte, 8'h00} >> (X mod 8); mask0 = W[15:8], mask1 = W[7:0].
REQ-024: FB0_REQ addresses byte (Y+r, X/8), then FB0_WAIT for 2 cycles.
REQ-025: FB0_WR asserts fb_we_out with fb_data_out = old ^ mask0; collision flag |= |(old & mask0).
REQ-026: FB1 states address (Y+r, X/8+1) and repeat REQ-024/REQ-025 using mask1.
REQ-027: FB1 states are executed only when X mod 8 != 0 and X/8 != 7; otherwise they are skipped, so right-edge pixels clip and do not wrap.
REQ-028: Aligned row = 7 cycles (1+2+1+2+1); unaligned non-clipped row = 11 cycles.
REQ-029: After a row, r increments; the draw ends (-> DONE) when r == n_in or Y+r == 32 (bottom clip, no vertical wrap).
REQ-030: n_in == 0 -> DONE directly after IDLE; no reads, no writes, collision = 0.
REQ-031: CLEAR writes 8'h00 to addresses 0..255, one per cycle (256 cycles), then -> DONE; collision = 0.
REQ-032: DONE lasts one cycle: done_out=1, collision_out loaded, busy_out=0, -> IDLE.
REQ-033: fb_we_out is high only in FB0_WR, FB1_WR and CLEAR; spr/fb addresses hold their last value otherwise.
REQ-034: Row, column and shift arithmetic use 5-, 3- and 3-bit fields respectively; Y+r uses 6 bits for the clip compare.

Reset
REQ-035: When rst_in=0 at a clock edge: state=IDLE, busy_out=0, done_out=0, collision_out=0, fb_we_out=0, fb_data_out=0, fb_addr_out=0, spr_addr_out=0, internal collision flag=0.
REQ-036: Reset mid-command aborts immediately; no write is issued on or after the reset edge, and done_out is not pulsed.

Verification
REQ-037: Aligned draw: fb zeroed, X=8, Y=0, n=1, sprite 0xF0 -> one write, addr 0x0001, data 0xF0, collision 0, done 7 cycles after SPR_REQ.
REQ-038: Unaligned draw: X=3, Y=2, sprite 0xFF over zeroed fb -> writes addr 0x0010 = 0x1F and 0x0011 = 0xE0.
REQ-039: Collision: redraw the same sprite at the same location -> bytes return to 0x00, collision_out=1.
REQ-040: Clipping: X=61, Y=30, n=4, sprite 0xFF -> writes only addrs 0xF7 (0x07) and 0xFF (0x07); 2 rows drawn, no wrap.
REQ-041: CLEAR -> 256 consecutive writes of 0x00 at addrs 0..255, done_out 1 cycle later; start_in pulsed mid-clear is ignored.
REQ-042: rst_in=0 during FB0_WAIT -> no subsequent fb_we_out, busy_out=0; a fresh start_in afterwards behaves as in REQ-037.
